pipe_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RISC-V core. Decides each cycle whether the PC register, the IF/ID register and the ID/EX register advance, hold or are flushed to `INST_NOP`. Sources are EX-stage jumps and branches, ID-stage load-use hazards, and hold requests from the multi-cycle divider and the bus arbiter. Sits beside the datapath; its outputs drive the hold and flush inputs of `pc_reg`, `if_id` and `id_ex`.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/pipe_perf_cnt.sv | 21 ++
 rtl/pipe_ctrl.sv | 112 +++++++++++
 tb/tb_pipe_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core definitions: NOP encoding, hazard-controller state type and
// the default instruction address width.
package riscv_pkg;

  localparam logic [31:0] INST_NOP   = 32'h0000_0013;
  localparam int          ADDR_W_DEF = 32;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Free-running performance counter with an increment enable. It wraps modulo
// 2^W and clears on the synchronous active-low reset.
module pipe_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  // Count one event per enabled cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_o <= '0;
    end else if (inc_i) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller for the 5-stage core. Each cycle it decides
// whether PC, IF/ID and ID/EX advance, hold or flush. The priority order is
// external hold, then redirect (live or deferred), then load-use bubble.
// Optional stall/redirect counters are built when PIPE_CTRL_PERF_EN is
// defined; otherwise the count outputs are tied to zero.
module pipe_ctrl
  import riscv_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              load_use_i,
  input  logic              hold_ex_i,
  input  logic              hold_bus_i,
  output logic              pc_hold_o,
  output logic              if_id_hold_o,
  output logic              id_ex_hold_o,
  output logic              if_id_flush_o,
  output logic              id_ex_flush_o,
  output logic              pc_jump_o,
  output logic [ADDR_W-1:0] pc_jump_addr_o,
  output logic [PERF_W-1:0] stall_cnt_o,
  output logic [PERF_W-1:0] flush_cnt_o
);

  ctrl_state_t       r_state;
  logic              r_pend_vld;
  logic [ADDR_W-1:0] r_pend_addr;

  logic w_hold_any;
  logic w_pend_live;
  logic w_redirect;
  logic w_bubble;

  assign w_hold_any  = hold_ex_i | hold_bus_i;
  // A deferred redirect only exists across a hold, so it can only fire on
  // the HOLD release cycle.
  assign w_pend_live = r_pend_vld & (r_state == HOLD);
  assign w_redirect  = ~w_hold_any & (jump_flag_i | w_pend_live);
  // The load-use source is being flushed when a redirect fires, so it loses.
  assign w_bubble    = ~w_hold_any & ~w_redirect & load_use_i;

  // Turn the winning request into stage controls; all quiet while in reset.
  always_comb begin
    // NOTE: every output is defaulted first so no branch can leave one unassigned and infer a latch.
    pc_hold_o      = 1'b0;
    if_id_hold_o   = 1'b0;
    id_ex_hold_o   = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    pc_jump_o      = 1'b0;
    pc_jump_addr_o = '0;
    if (rst_n) begin
      pc_hold_o     = w_hold_any | w_bubble;
      if_id_hold_o  = w_hold_any | w_bubble;
      id_ex_hold_o  = w_hold_any;
      if_id_flush_o = w_redirect;
      id_ex_flush_o = w_redirect | w_bubble;
      pc_jump_o     = w_redirect;
      // Live jump beats the deferred one; no stale address when idle.
      if (w_redirect) begin
        pc_jump_addr_o = jump_flag_i ? jump_addr_i : r_pend_addr;
      end
    end
  end

  // Track RUN/HOLD and remember the last jump seen while frozen.
  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      r_state     <= RUN;
      r_pend_vld  <= 1'b0;
      r_pend_addr <= '0;
    end else if (w_hold_any) begin
      r_state <= HOLD;
      if (jump_flag_i) begin
        r_pend_vld  <= 1'b1;
        r_pend_addr <= jump_addr_i;
      end
    end else begin
      r_state <= RUN;
      if (w_redirect) begin
        r_pend_vld  <= 1'b0;
        r_pend_addr <= '0;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  pipe_perf_cnt #(.W(PERF_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (pc_hold_o),
    .cnt_o (stall_cnt_o)
  );

  pipe_perf_cnt #(.W(PERF_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (pc_jump_o),
    .cnt_o (flush_cnt_o)
  );
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus a randomized run,
// all compared against a behavioural model of the hazard priority rules.
module tb_pipe_ctrl;
  import riscv_pkg::*;

  localparam int AW = 32;
  localparam int PW = 32;

  typedef struct packed {
    logic          pc_hold;
    logic          if_id_hold;
    logic          id_ex_hold;
    logic          if_id_flush;
    logic          id_ex_flush;
    logic          pc_jump;
    logic [AW-1:0] addr;
    logic [PW-1:0] stall;
    logic [PW-1:0] flush;
  } out_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          jump_flag_i;
  logic [AW-1:0] jump_addr_i;
  logic          load_use_i;
  logic          hold_ex_i;
  logic          hold_bus_i;
  logic          pc_hold_o;
  logic          if_id_hold_o;
  logic          id_ex_hold_o;
  logic          if_id_flush_o;
  logic          id_ex_flush_o;
  logic          pc_jump_o;
  logic [AW-1:0] pc_jump_addr_o;
  logic [PW-1:0] stall_cnt_o;
  logic [PW-1:0] flush_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: a deferred redirect target and the event tallies.
  logic          m_pend_vld;
  logic [AW-1:0] m_pend_addr;
  logic [PW-1:0] m_stalls;
  logic [PW-1:0] m_redirects;

  always #5 clk = ~clk;

  pipe_ctrl #(.ADDR_W(AW), .PERF_W(PW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .jump_flag_i    (jump_flag_i),
    .jump_addr_i    (jump_addr_i),
    .load_use_i     (load_use_i),
    .hold_ex_i      (hold_ex_i),
    .hold_bus_i     (hold_bus_i),
    .pc_hold_o      (pc_hold_o),
    .if_id_hold_o   (if_id_hold_o),
    .id_ex_hold_o   (id_ex_hold_o),
    .if_id_flush_o  (if_id_flush_o),
    .id_ex_flush_o  (id_ex_flush_o),
    .pc_jump_o      (pc_jump_o),
    .pc_jump_addr_o (pc_jump_addr_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
  );

  // Expected outputs from the rules: hold > redirect > load-use > idle.
  function automatic out_t model_out();
    out_t o = '0;
`ifdef PIPE_CTRL_PERF_EN
    o.stall = m_stalls;
    o.flush = m_redirects;
`endif
    if (!rst_n) return o;
    if (hold_ex_i || hold_bus_i) begin
      o.pc_hold = 1'b1; o.if_id_hold = 1'b1; o.id_ex_hold = 1'b1;
    end else if (jump_flag_i || m_pend_vld) begin
      o.pc_jump = 1'b1; o.if_id_flush = 1'b1; o.id_ex_flush = 1'b1;
      o.addr = jump_flag_i ? jump_addr_i : m_pend_addr;
    end else if (load_use_i) begin
      o.pc_hold = 1'b1; o.if_id_hold = 1'b1; o.id_ex_flush = 1'b1;
    end
    return o;
  endfunction

  // Advance the model across one clock edge given the expected outputs.
  task automatic model_step(input out_t e);
    if (!rst_n) begin
      m_pend_vld = 1'b0; m_pend_addr = '0; m_stalls = '0; m_redirects = '0;
    end else begin
      if (e.pc_hold) m_stalls = m_stalls + 1;
      if (e.pc_jump) m_redirects = m_redirects + 1;
      if (hold_ex_i || hold_bus_i) begin
        if (jump_flag_i) begin m_pend_vld = 1'b1; m_pend_addr = jump_addr_i; end
      end else if (e.pc_jump) begin
        m_pend_vld = 1'b0;
      end
    end
  endtask

  // Drive one cycle of inputs (called at negedge), sample mid-low-phase,
  // then cross the posedge and return at the next negedge.
  task automatic cycle(input logic rst, input logic jf, input logic [AW-1:0] ja,
                       input logic lu, input logic hx, input logic hb,
                       output out_t exp_o, output out_t obs_o);
    rst_n = rst; jump_flag_i = jf; jump_addr_i = ja;
    load_use_i = lu; hold_ex_i = hx; hold_bus_i = hb;
    #1;
    exp_o = model_out();
    obs_o = {pc_hold_o, if_id_hold_o, id_ex_hold_o, if_id_flush_o, id_ex_flush_o,
             pc_jump_o, pc_jump_addr_o, stall_cnt_o, flush_cnt_o};
    @(posedge clk);
    model_step(exp_o);
    @(negedge clk);
  endtask

  task automatic test_reset();
    out_t e, o;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom), e, o);
      n_tests++;
      if (o.pc_hold | o.if_id_hold | o.id_ex_hold | o.if_id_flush | o.id_ex_flush | o.pc_jump | (|o.addr)) begin
        n_fail++; $display("FAIL reset_outputs: got %h, want all control outputs 0", o);
      end
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 0, '0, 0, 0, 0, e, o);
      n_tests++;
      if (o !== e || o !== out_t'(0)) begin
        n_fail++; $display("FAIL idle_after_reset: got %h, want %h", o, e);
      end
    end
    n_tests++;
    if (dut.r_state !== RUN) begin
      n_fail++; $display("FAIL reset_state: got %0d, want RUN", dut.r_state);
    end
  endtask

  task automatic test_load_use();
    out_t e, o;
    cycle(1'b1, 0, '0, 1, 0, 0, e, o);
    n_tests++;
    if (o !== e || !o.pc_hold || !o.if_id_hold || !o.id_ex_flush || o.id_ex_hold || o.pc_jump) begin
      n_fail++; $display("FAIL load_use_bubble: got %h, want %h", o, e);
    end
    cycle(1'b1, 0, '0, 0, 0, 0, e, o);
    n_tests++;
    if (o !== e || o.pc_hold || o.id_ex_flush) begin
      n_fail++; $display("FAIL load_use_one_cycle: got %h, want %h", o, e);
    end
`ifdef PIPE_CTRL_PERF_EN
    n_tests++;
    if (o.stall !== 32'd1) begin
      n_fail++; $display("FAIL load_use_stall_cnt: got %0d, want 1", o.stall);
    end
`endif
  endtask

  task automatic test_jump_over_load_use();
    out_t e, o;
    cycle(1'b1, 1, 32'h0000_0100, 1, 0, 0, e, o);
    n_tests++;
    if (o !== e || !o.pc_jump || o.addr !== 32'h100 || !o.if_id_flush || !o.id_ex_flush || o.pc_hold) begin
      n_fail++; $display("FAIL jump_beats_load_use: got %h, want %h", o, e);
    end
    cycle(1'b1, 0, '0, 0, 0, 0, e, o);
    n_tests++;
    if (o !== e || o.pc_jump || o.addr !== '0) begin
      n_fail++; $display("FAIL jump_no_stale_addr: got %h, want %h", o, e);
    end
  endtask

  // hold_bus for 4 cycles with a jump on cycle 2; release cycle carries rel_jf/rel_addr.
  task automatic run_hold(input logic rel_jf, input logic [AW-1:0] rel_addr,
                          input logic [AW-1:0] want_addr, input string tag);
    out_t e, o;
    for (int c = 1; c <= 4; c++) begin
      cycle(1'b1, c == 2, (c == 2) ? 32'h0000_0200 : 32'h0, 0, 0, 1, e, o);
      n_tests++;
      if (o !== e || !o.pc_hold || !o.if_id_hold || !o.id_ex_hold || o.pc_jump || o.if_id_flush) begin
        n_fail++; $display("FAIL %s_hold_c%0d: got %h, want %h", tag, c, o, e);
      end
    end
    cycle(1'b1, rel_jf, rel_addr, 0, 0, 0, e, o);
    n_tests++;
    if (o !== e || !o.pc_jump || o.addr !== want_addr || !o.if_id_flush || !o.id_ex_flush || o.pc_hold) begin
      n_fail++; $display("FAIL %s_release: got %h, want %h", tag, o, e);
    end
    cycle(1'b1, 0, '0, 0, 0, 0, e, o);
    n_tests++;
    if (o !== e || o.pc_jump) begin
      n_fail++; $display("FAIL %s_after_release: got %h, want %h", tag, o, e);
    end
  endtask

  task automatic test_hold_pending();
    run_hold(1'b0, 32'h0, 32'h0000_0200, "hold_pending");
  endtask

  task automatic test_hold_override();
    run_hold(1'b1, 32'h0000_0300, 32'h0000_0300, "hold_override");
  endtask

  task automatic test_reset_mid_hold();
    out_t e, o;
    cycle(1'b1, 1, 32'h0000_0400, 0, 1, 0, e, o);
    cycle(1'b1, 0, '0, 0, 1, 0, e, o);
    cycle(1'b0, 0, '0, 0, 1, 0, e, o);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 0, '0, 0, 0, 0, e, o);
      n_tests++;
      if (o !== e || o.pc_jump || o.pc_hold || o.if_id_flush || o.id_ex_flush || o.addr !== '0) begin
        n_fail++; $display("FAIL reset_drops_pending_%0d: got %h, want %h", i, o, e);
      end
    end
  endtask

  task automatic test_random();
    out_t e, o;
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(39) != 0), ($urandom_range(3) == 0), $urandom,
            ($urandom_range(2) == 0), ($urandom_range(4) == 0), ($urandom_range(4) == 0), e, o);
      n_tests++;
      if (o !== e) begin
        n_fail++; $display("FAIL random_%0d: got %h, want %h", i, o, e);
      end
    end
  endtask

  initial begin
    m_pend_vld = 1'b0; m_pend_addr = '0; m_stalls = '0; m_redirects = '0;
    rst_n = 1'b0; jump_flag_i = 1'b0; jump_addr_i = '0;
    load_use_i = 1'b0; hold_ex_i = 1'b0; hold_bus_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_load_use();
    test_jump_over_load_use();
    test_hold_pending();
    test_hold_override();
    test_reset_mid_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
